// File: rtl/latch_queue.sv
// Clocked replacement for an octal address latch: captures d on each falling edge of the
// strobe g into a small FIFO and shows the head on a tri-state bus. Optional macro: LATCH_QUEUE_PARITY_EN.
module latch_queue #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int TRANSPARENT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         d,
  input  logic                     g,
  input  logic                     oe_n,
  inout  tri   [WIDTH-1:0]         q,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
`ifdef LATCH_QUEUE_PARITY_EN
  ,
  inout  tri                       q_par,
  output logic                     perr
`endif
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);
  localparam bit             FLOW       = (TRANSPARENT != 0);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold;
  logic             g_d1;
  logic [WIDTH-1:0] mem [DEPTH];

  logic push;
  logic pop_ok;
  logic drop;
  logic wr_en;
  logic flow_through;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);

  // A capture is the strobe's falling edge; a simultaneous pop frees the slot even when full.
  assign push   = g_d1 & ~g;
  assign pop_ok = pop & ~empty;
  assign drop   = push & full & ~pop_ok;
  assign wr_en  = push & ~drop;

  assign flow_through = FLOW & empty & g;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold     <= '0;
      g_d1     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      g_d1 <= g;
      if (g) hold <= d;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; only the pointers and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= hold;
  end

  logic [WIDTH-1:0] q_val;

  // NOTE: q_val gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    q_val = hold;
    if (flow_through) q_val = d;
    else if (!empty) q_val = mem[rd_ptr];
  end

  assign q = oe_n ? {WIDTH{1'bz}} : q_val;

`ifdef LATCH_QUEUE_PARITY_EN
  // Odd parity: the stored bit makes the total number of ones odd.
  logic par_mem [DEPTH];
  logic par_val;
  logic head_par_calc;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_ptr] <= ~^hold;
  end

  assign head_par_calc = ~^mem[rd_ptr];

  always_comb begin
    par_val = ~^q_val;
    if (!flow_through && !empty) par_val = par_mem[rd_ptr];
  end

  assign q_par = oe_n ? 1'bz : par_val;
  assign perr  = ~oe_n & ~empty & (par_mem[rd_ptr] != head_par_calc);
`endif

endmodule

// File: tb/tb_latch_queue.sv
// Scoreboard bench for latch_queue: captures queue expected values, a monitor compares them
// against q whenever the bench pops a non-empty queue with the output enabled.
module tb_latch_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] d;
  logic       g;
  logic       oe_n;
  logic       pop;
  logic       clr_ovf;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  tri   [7:0] q;
  logic [7:0] bus_val;
  logic       bus_en;
`ifdef LATCH_QUEUE_PARITY_EN
  tri         q_par;
  logic       perr;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];

  assign q = bus_en ? bus_val : 8'hzz;

  always #5 clk = ~clk;

  latch_queue #(.WIDTH(8), .DEPTH(4), .TRANSPARENT(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d        (d),
    .g        (g),
    .oe_n     (oe_n),
    .q        (q),
    .pop      (pop),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
`ifdef LATCH_QUEUE_PARITY_EN
    ,
    .q_par    (q_par),
    .perr     (perr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe pulse; the capture lands on the second edge.
  task automatic strobe(input logic [7:0] val, input bit expect_kept);
    g = 1'b1;
    d = val;
    tick();
    g = 1'b0;
    if (expect_kept) exp_q.push_back(val);
    tick();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  // Monitor: the value on q while a pop is accepted is the head being consumed.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && pop && !empty && !oe_n) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_data: got %0h with nothing expected", q);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", q, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    d       = '0;
    g       = 1'b0;
    oe_n    = 1'b0;
    pop     = 1'b0;
    clr_ovf = 1'b0;
    bus_val = '0;
    bus_en  = 1'b0;
    #12 reset_n = 1'b1;
    tick();
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_ovf", overflow, 0);

    // Asynchronous reset with three entries in flight.
    strobe(8'hE1, 1'b0);
    strobe(8'hE2, 1'b0);
    strobe(8'hE3, 1'b0);
    check("pre_reset_count", count, 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    check("async_ovf", overflow, 0);
    reset_n = 1'b1;

    // Flow-through while empty and g high.
    g = 1'b1;
    d = 8'hA5;
    #1;
    check("transparent_q", q, 8'hA5);

    // One strobe held high three cycles gives exactly one entry.
    tick();
    d = 8'h12;
    tick();
    tick();
    d = 8'h34;
    tick();
    g = 1'b0;
    exp_q.push_back(8'h34);
    tick();
    check("single_count", count, 1);
    check("single_q", q, 8'h34);
    do_pop();
    check("single_empty", empty, 1);
    check("hold_q", q, 8'h34);

    // Fill, drop one, drain in order, then clear overflow.
    for (int i = 1; i <= 4; i++) strobe(8'(i), 1'b1);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    strobe(8'h05, 1'b0);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 4);
    for (int i = 0; i < 4; i++) do_pop();
    check("drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Set beats clear when they land on the same edge.
    for (int i = 0; i < 4; i++) strobe(8'h11 * 8'(i + 1), 1'b1);
    clr_ovf = 1'b1;
    strobe(8'h99, 1'b0);
    clr_ovf = 1'b0;
    check("set_wins_ovf", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Capture with a simultaneous pop while full.
    g = 1'b1;
    d = 8'h55;
    tick();
    g = 1'b0;
    pop = 1'b1;
    exp_q.push_back(8'h55);
    tick();
    pop = 1'b0;
    check("pushpop_count", count, 4);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_head", q, 8'h22);
    for (int i = 0; i < 4; i++) do_pop();
    check("pushpop_empty", empty, 1);

    // Released bus: another driver's value must pass through untouched.
    strobe(8'h3C, 1'b1);
    oe_n    = 1'b1;
    bus_en  = 1'b1;
    bus_val = 8'h5A;
    #1;
    check("released_bus_5a", q, 8'h5A);
    bus_val = 8'hA5;
    #1;
    check("released_bus_a5", q, 8'hA5);
    bus_en = 1'b0;
    oe_n   = 1'b0;
    #1;
    check("enabled_q", q, 8'h3C);
    do_pop();

    // Ten values through four slots to wrap both pointers.
    for (int i = 0; i < 10; i++) begin
      strobe(8'h40 + 8'(i), 1'b1);
      if (i >= 2) do_pop();
    end
    do_pop();
    do_pop();
    check("wrap_empty", empty, 1);

    // Pop on empty changes nothing.
    do_pop();
    check("empty_pop_count", count, 0);
    check("empty_pop_empty", empty, 1);
    check("empty_pop_q", q, 8'h49);

`ifdef LATCH_QUEUE_PARITY_EN
    strobe(8'h07, 1'b1);
    check("par_07", q_par, 0);
    check("perr_07", perr, 0);
    do_pop();
    strobe(8'h03, 1'b1);
    check("par_03", q_par, 1);
    dut.par_mem[dut.rd_ptr] = ~dut.par_mem[dut.rd_ptr];
    #1;
    check("perr_flip", perr, 1);
    do_pop();
    check("perr_gone", perr, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_queue.md
Name: latch_queue

Overview:
- Parametrised, clocked successor to the octal transparent latch used on the PC address/data bus.
- Captures the bus value on each falling edge of the latch strobe g, as an ALE-style latch does.
- Holds up to DEPTH captured values in order, so back-to-back bus cycles are not lost while downstream logic is still busy.
- The head value is presented on a tri-state output controlled by oe_n; status flags report fill level and overflow.

Parameters:
- WIDTH, 8, data width of d and q.
- DEPTH, 4, number of entries; power of two, minimum 2.
- TRANSPARENT, 1, when 1 and the queue is empty, q follows d combinationally while g is high (classic latch flow-through).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- d  input  WIDTH  data to latch.
- g  input  1  latch strobe, active high, sampled on clk.
- oe_n  input  1  output enable, active low.
- q  inout tri  WIDTH  head value when enabled, all-Z otherwise.
- pop  input  1  consume the head entry.
- clr_ovf  input  1  clear the sticky overflow flag.
- count  output  log2(DEPTH)+1  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set when a capture is dropped.

Behaviour:
- Reset is asynchronous on reset_n low. It clears:
  - write pointer, read pointer and count to 0;
  - hold register to 0, g_d1 to 0, overflow to 0.
- Reset values after release: empty=1, full=0, count=0, overflow=0.
- Entry contents are not reset and are don't-care.
- Reset mid-capture discards the capture in progress; the queue is empty afterwards.
- Hold register: every rising clk edge on which g=1 loads d. It therefore holds d from the last cycle g was high.
- Capture (push): the rising edge where g_d1=1 and g=0 (strobe falling edge) writes the hold register at the write pointer.
  - Write pointer increments modulo DEPTH; count +1.
  - One capture per strobe pulse; g held high for N cycles still gives one entry.
- Pop: pop=1 with empty=0 advances the read pointer modulo DEPTH; count -1.
  - Pop with empty=1 is ignored; no state change.
- Push while full:
  - without pop, the capture is dropped, contents are unchanged, and overflow is set on that edge;
  - with simultaneous pop, both occur, count stays DEPTH, no overflow.
- Push and pop in the same cycle when not full and not empty: count unchanged, both pointers advance.
- Push and pop in the same cycle when empty: the pop is ignored, the push succeeds, count becomes 1.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty derive from count, not pointer compare.
- overflow:
  - clears on clr_ovf=1;
  - if the set and clear conditions coincide, set wins.
- q drive, combinational, with zero added latency. Priority order:
  - oe_n=1 gives all-Z.
  - Otherwise, if TRANSPARENT=1 and empty=1 and g=1, q=d.
  - Otherwise, if empty=0, q = entry at the read pointer.
  - Otherwise, q = hold register.
- Latency:
  - A captured value appears on q (queue previously empty, g low) on the same edge that pushes it, i.e. the rising clk edge sampling g=0.
  - Pop exposes the next entry after one edge.
- count, empty, full and overflow are registered or derived from registered state only, so they are glitch-free.

Optional Feature:
- Macro: LATCH_QUEUE_PARITY_EN.
- When defined:
  - each entry stores an extra odd-parity bit computed from the hold register at capture;
  - output port q_par (inout tri, 1) is added. It is Z when oe_n=1, otherwise the stored parity of the displayed entry.
  - In the transparent and hold-register cases, q_par is the parity computed live from the displayed value.
  - Output port perr (output, 1) is added. It is 1 when oe_n=0, empty=0, and the stored parity mismatches the recomputed parity of the head entry.
- When undefined: no q_par/perr ports, no parity storage; behaviour is otherwise identical.

Test Plan:
- Reset and transparency:
  - assert reset_n=0 mid-operation with count=3 -> count=0, empty=1, overflow=0 immediately, without waiting for a clk edge;
  - then oe_n=0, g=1, d=8'hA5 -> q=8'hA5 combinationally.
- Single capture: g high 3 cycles with d=8'h12 then 8'h34 on the last high cycle, g low -> one entry, count=1, q=8'h34; pop -> empty=1, q shows hold register 8'h34.
- Fill and overflow (DEPTH=4):
  - strobe values 1,2,3,4 -> full=1;
  - fifth strobe value 5 -> dropped, overflow=1, count=4;
  - pops return 1,2,3,4 in order;
  - clr_ovf -> overflow=0.
- Simultaneous push+pop when full: 4 entries, strobe fall with pop=1 -> count stays 4, overflow=0, head advances, new value at tail.
- Tri-state and wrap: oe_n=1 -> q=8'hZZ; push/pop 10 values through DEPTH=4 -> order preserved across pointer wrap; pop on empty -> no change.
- Parity (LATCH_QUEUE_PARITY_EN defined): capture 8'h07 -> q_par=0; capture 8'h03 -> q_par=1; force a stored parity bit flip -> perr=1 while that entry is at head.
